// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path definitions: FSM state encodings, instruction width and PC step.
// Reused by the fetch unit, decode and the future branch unit.
package instruction_fetch_unit_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_STEP     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_pc_counter.sv
// Program counter for the fetch unit: reset/load/increment with wrap at the end of
// instruction memory, plus a combinational legality check on redirect targets.
module fetch_pc_counter
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            MEM_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_target,
    input  logic                  i_incr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_target_bad
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC   = ADDR_WIDTH'(MEM_BYTES - PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    always_comb begin
        w_next_pc = (r_pc == LAST_PC) ? '0 : r_pc + ADDR_WIDTH'(PC_STEP);
    end

    // Out-of-range targets are rejected like misaligned ones so no illegal address is ever presented.
    assign o_target_bad = (i_target[1:0] != 2'b00) || (i_target >= MEM_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_incr) begin
            r_pc <= w_next_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequences a combinational instruction memory and hands fetched
// words to decode over valid/ready, with redirect, halt, stall and misaligned-target fault.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            MEM_BYTES  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fault,
    output logic [1:0]            state
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic                  r_instr_valid;
    logic [DATA_WIDTH-1:0] r_instr_data;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic                  r_fault;

    logic [ADDR_WIDTH-1:0] w_pc;
    logic                  w_target_bad;
    logic                  w_active;
    logic                  w_redirect;
    logic                  w_redirect_ok;
    logic                  w_redirect_bad;
    logic                  w_slot_free;
    logic                  w_fetch;
    logic                  w_accept;

    assign w_active       = (r_state == ST_IDLE) || (r_state == ST_FETCH);
    assign w_redirect     = redirect_valid && w_active;
    assign w_redirect_ok  = w_redirect && !w_target_bad;
    assign w_redirect_bad = w_redirect && w_target_bad;
    assign w_slot_free    = !r_instr_valid || instr_ready;
    assign w_accept       = r_instr_valid && instr_ready;
    // Redirect and halt both pre-empt a fetch in the same cycle.
    assign w_fetch        = (r_state == ST_FETCH) && enable && !redirect_valid
                            && !halt_req && w_slot_free;

    fetch_pc_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC),
        .MEM_BYTES  (MEM_BYTES)
    ) u_pc (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_redirect_ok),
        .i_target     (redirect_target),
        .i_incr       (w_fetch),
        .o_pc         (w_pc),
        .o_target_bad (w_target_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE, ST_FETCH: begin
                if (w_redirect_bad) begin
                    w_next_state = ST_FAULT;
                end else if (halt_req) begin
                    w_next_state = ST_HALT;
                end else if (enable) begin
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HALT, ST_FAULT: w_next_state = r_state;
            default:           w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
            r_instr_data  <= '0;
            r_instr_pc    <= '0;
            r_fault       <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_instr_valid <= 1'b0;
            end else if (w_fetch) begin
                r_instr_valid <= 1'b1;
                r_instr_data  <= imem_data;
                r_instr_pc    <= w_pc;
            end else if (w_accept) begin
                r_instr_valid <= 1'b0;
            end
            if (w_redirect_bad) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign imem_address = w_pc;
    assign instr_valid  = r_instr_valid;
    assign instr_data   = r_instr_data;
    assign instr_pc     = r_instr_pc;
    assign fault        = r_fault;
    assign state        = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall, redirect, wrap,
// halt with drain, async reset and fault on illegal redirect targets.
module tb_instruction_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_FETCH = 32'd1;
    localparam logic [31:0] S_HALT  = 32'd2;
    localparam logic [31:0] S_FAULT = 32'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          halt_req;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          fault;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hC0, a[7:0], ~a[7:0], 8'h5A};
    endfunction

    assign imem_data = mem_word(imem_address);

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'd0),
        .MEM_BYTES  (256)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .halt_req        (halt_req),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .fault           (fault),
        .state           (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] pc);
        check({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, " pc"}, instr_pc, pc);
        check({tag, " data"}, instr_data, mem_word(pc));
    endtask

    initial begin
        reset           = 1'b1;
        enable          = 1'b0;
        halt_req        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b1;
        step();
        step();
        check("rst state", {30'd0, state}, S_IDLE);
        check("rst valid", {31'd0, instr_valid}, 32'd0);
        check("rst instr_pc", instr_pc, 32'd0);
        check("rst instr_data", instr_data, 32'd0);
        check("rst fault", {31'd0, fault}, 32'd0);
        check("rst addr", imem_address, 32'd0);
        reset = 1'b0;

        // Start fetching: IDLE->FETCH on the first edge, first word on the second
        enable = 1'b1;
        step();
        check("start state", {30'd0, state}, S_FETCH);
        check("start valid", {31'd0, instr_valid}, 32'd0);
        step();
        check_word("seq0", 32'd0);
        step();
        check_word("seq4", 32'd4);
        step();
        check_word("seq8", 32'd8);

        // Stall three cycles with instr_pc=8
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_word("stall", 32'd8);
            check("stall addr", imem_address, 32'd12);
        end
        instr_ready = 1'b1;
        step();
        check_word("release12", 32'd12);
        step();
        check_word("seq16", 32'd16);

        // Redirect to 0x40 flushes the in-flight word
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("redir valid", {31'd0, instr_valid}, 32'd0);
        check("redir addr", imem_address, 32'h40);
        step();
        check_word("redir40", 32'h40);
        step();
        check_word("redir44", 32'h44);

        // Wrap from the last word back to 0
        redirect_valid  = 1'b1;
        redirect_target = 32'd252;
        step();
        redirect_valid = 1'b0;
        check("wrap flush", {31'd0, instr_valid}, 32'd0);
        step();
        check_word("wrap252", 32'd252);
        step();
        check_word("wrap0", 32'd0);
        check("wrap addr", imem_address, 32'd4);

        // Halt while a word is stalled: held, then drained, pc frozen
        instr_ready = 1'b0;
        halt_req    = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt state", {30'd0, state}, S_HALT);
        check_word("halt hold", 32'd0);
        check("halt addr", imem_address, 32'd4);
        step();
        check_word("halt hold2", 32'd0);
        instr_ready = 1'b1;
        step();
        check("halt drained", {31'd0, instr_valid}, 32'd0);
        check("halt state2", {30'd0, state}, S_HALT);
        check("halt addr2", imem_address, 32'd4);
        step();
        check("halt frozen", imem_address, 32'd4);

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check("async state", {30'd0, state}, S_IDLE);
        check("async addr", imem_address, 32'd0);
        check("async valid", {31'd0, instr_valid}, 32'd0);
        #1;
        reset = 1'b0;

        // Misaligned redirect -> fault
        step();
        step();
        check_word("pre fault", 32'd0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("mis fault", {31'd0, fault}, 32'd1);
        check("mis state", {30'd0, state}, S_FAULT);
        check("mis valid", {31'd0, instr_valid}, 32'd0);
        check("mis addr", imem_address, 32'd4);
        step();
        check("mis sticky", {31'd0, fault}, 32'd1);
        check("mis valid2", {31'd0, instr_valid}, 32'd0);
        check("mis addr2", imem_address, 32'd4);

        reset = 1'b1;
        step();
        check("clr fault", {31'd0, fault}, 32'd0);
        check("clr addr", imem_address, 32'd0);
        check("clr state", {30'd0, state}, S_IDLE);
        reset = 1'b0;

        // Out-of-range target is also a fault
        step();
        step();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("range fault", {31'd0, fault}, 32'd1);
        check("range state", {30'd0, state}, S_FAULT);
        check("range addr", imem_address, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
